// File: rtl/cr_osf_out_arb_pkg.sv
// Shared types for the OSF output arbiter: stream beat bus,
// arbiter state encoding and the start-of-frame tuser marker.
package cr_osf_out_arb_pkg;

    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } osf_arb_st_e;

    localparam logic [7:0] OSF_SOT_TUSER = 8'h01;

endpackage

// File: rtl/cr_osf_rr_pick.sv
// Rotating-priority encoder: returns the first requester found
// searching from ptr upward, wrapping modulo N_SRC.
module cr_osf_rr_pick #(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] ptr,
    output logic [$clog2(N_SRC)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(N_SRC);

    int best;
    int rank;

    // Lowest distance from ptr (mod N_SRC) wins.
    always_comb begin
        idx  = '0;
        best = N_SRC;
        rank = 0;
        for (int i = 0; i < N_SRC; i++) begin
            rank = i - int'(ptr);
            if (rank < 0) begin
                rank = rank + N_SRC;
            end
            if (req[i] && (rank < best)) begin
                best = rank;
                idx  = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cr_osf_out_arb.sv
// Frame-level round-robin arbiter sharing the OSF output stream
// between FWFT source FIFOs; checks SOT/tlast framing.
module cr_osf_out_arb
    import cr_osf_out_arb_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int BCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  axi4s_dp_bus_t            src_head [N_SRC],
    input  logic [N_SRC-1:0]         src_empty,
    output logic [N_SRC-1:0]         src_rd,
    input  logic                     ob_rdy,
    output axi4s_dp_bus_t            axi4s_out,
    output logic                     axi4s_mstr_rd,
    output logic                     grant_vld,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     frm_done,
    output logic [$clog2(N_SRC)-1:0] frm_src,
    output logic [BCNT_W-1:0]        frm_beats,
    output logic                     prot_err
);

    localparam int IW = $clog2(N_SRC);

    osf_arb_st_e       state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    axi4s_dp_bus_t     head;
    logic              head_vld;
    logic              pop;
    logic              first_beat;
    logic              bcnt_sat;

    cr_osf_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req (~src_empty),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign head       = src_head[grant_id_q];
    assign head_vld   = ~src_empty[grant_id_q];
    assign first_beat = (bcnt_q == '0);
    assign bcnt_sat   = (bcnt_q == '1);
    assign grant_vld  = (state_q == ARB_XFER);
    assign grant_id   = grant_id_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        bcnt_d        = bcnt_q;
        src_rd        = '0;
        axi4s_out     = '0;
        axi4s_mstr_rd = 1'b0;
        pop           = 1'b0;
        frm_done      = 1'b0;
        frm_src       = grant_id_q;
        frm_beats     = bcnt_sat ? bcnt_q : bcnt_q + 1'b1;
        prot_err      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    bcnt_d     = '0;
                    state_d    = ARB_XFER;
                end
            end
            ARB_XFER: begin
                axi4s_out        = head;
                axi4s_out.tvalid = head_vld;
                pop              = head_vld & ob_rdy;
                src_rd[grant_id_q] = pop;
                axi4s_mstr_rd    = pop;
                if (pop) begin
                    // SOT only on the first beat of a grant, never later.
                    prot_err = first_beat ? (head.tuser != OSF_SOT_TUSER)
                                          : (head.tuser == OSF_SOT_TUSER);
                    if (head.tlast) begin
                        frm_done = 1'b1;
                        rr_ptr_d = (grant_id_q == IW'(N_SRC - 1)) ?
                                   '0 : grant_id_q + 1'b1;
                        state_d  = ARB_IDLE;
                    end else if (!bcnt_sat) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            bcnt_q     <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_cr_osf_out_arb.sv
// Directed bench for cr_osf_out_arb: FWFT FIFO model per source,
// pop/frame/error logs, immediate-assertion checks.
module tb_cr_osf_out_arb;
    import cr_osf_out_arb_pkg::*;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ob_rdy;
    axi4s_dp_bus_t src_head [N];
    logic [N-1:0]  src_empty;
    logic [N-1:0]  src_rd;
    axi4s_dp_bus_t axi4s_out;
    logic          mstr_rd, grant_vld, frm_done, prot_err;
    logic [0:0]    grant_id, frm_src;
    logic [15:0]   frm_beats;

    logic [N-1:0]  s_src_rd;
    axi4s_dp_bus_t s_out;
    logic          s_mstr_rd, s_grant_vld, s_frm_done, s_prot_err;
    logic [0:0]    s_grant_id, s_frm_src;
    logic [3:0]    s_frm_beats;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    axi4s_dp_bus_t fq [N][$];
    int            pop_cyc [$];
    logic [63:0]   pop_data [$];
    int            fsrc_log [$];
    int            fbeats_log [$];
    int            sbeats_log [$];
    int            err_cyc [$];
    logic [N-1:0]  rd_s;

    cr_osf_out_arb #(.N_SRC(N), .BCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .src_head(src_head),
        .src_empty(src_empty), .src_rd(src_rd), .ob_rdy(ob_rdy),
        .axi4s_out(axi4s_out), .axi4s_mstr_rd(mstr_rd),
        .grant_vld(grant_vld), .grant_id(grant_id),
        .frm_done(frm_done), .frm_src(frm_src),
        .frm_beats(frm_beats), .prot_err(prot_err)
    );

    cr_osf_out_arb #(.N_SRC(N), .BCNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .src_head(src_head),
        .src_empty(src_empty), .src_rd(s_src_rd), .ob_rdy(ob_rdy),
        .axi4s_out(s_out), .axi4s_mstr_rd(s_mstr_rd),
        .grant_vld(s_grant_vld), .grant_id(s_grant_id),
        .frm_done(s_frm_done), .frm_src(s_frm_src),
        .frm_beats(s_frm_beats), .prot_err(s_prot_err)
    );

    always #5 clk = ~clk;

    function automatic void update_heads();
        for (int i = 0; i < N; i++) begin
            src_empty[i] = (fq[i].size() == 0);
            src_head[i]  = src_empty[i] ? '0 : fq[i][0];
        end
    endfunction

    // FIFO model: sample strobes at the edge, pop just after it.
    always @(posedge clk) begin
        cyc++;
        rd_s = src_rd;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i]) begin
                pop_cyc.push_back(cyc);
                pop_data.push_back(src_head[i].tdata);
            end
        end
        if (frm_done) begin
            fsrc_log.push_back(int'(frm_src));
            fbeats_log.push_back(int'(frm_beats));
        end
        if (s_frm_done) sbeats_log.push_back(int'(s_frm_beats));
        if (prot_err) err_cyc.push_back(cyc);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i]) void'(fq[i].pop_front());
        end
        update_heads();
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int s, logic [7:0] tu, logic tl, logic [63:0] d);
        axi4s_dp_bus_t b;
        b.tvalid = 1'b1;
        b.tlast  = tl;
        b.tuser  = tu;
        b.tdata  = d;
        fq[s].push_back(b);
        update_heads();
    endtask

    task automatic push_frame(int s, int n, logic [63:0] base);
        for (int k = 0; k < n; k++) begin
            push(s, (k == 0) ? 8'h01 : 8'h00, k == n - 1, base + 64'(k));
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        pop_data.delete();
        fsrc_log.delete();
        fbeats_log.delete();
        sbeats_log.delete();
        err_cyc.delete();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) fq[i].delete();
        update_heads();
    endtask

    task automatic wait_frames(string tag, int n, int budget);
        int k = 0;
        while (fsrc_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(fsrc_log.size()), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_src [4];
        logic [63:0] exp_dat [8];
        int a, b;

        rst_n  = 1'b0;
        ob_rdy = 1'b0;
        update_heads();
        repeat (2) @(negedge clk);
        chk("rst_grant_vld", 64'(grant_vld), 0);
        chk("rst_src_rd", 64'(src_rd), 0);
        chk("rst_tvalid", 64'(axi4s_out.tvalid), 0);
        chk("rst_grant_id", 64'(grant_id), 0);
        chk("rst_frm_done", 64'(frm_done), 0);
        chk("rst_prot_err", 64'(prot_err), 0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single 3-beat frame on src0
        @(negedge clk);
        push_frame(0, 3, 64'h10);
        ob_rdy = 1'b1;
        #1;
        chk("t1_idle_rd", 64'(src_rd), 0);
        chk("t1_idle_vld", 64'(grant_vld), 0);
        @(negedge clk);
        chk("t1_vld", 64'(grant_vld), 1);
        chk("t1_gid", 64'(grant_id), 0);
        chk("t1_rd0", 64'(src_rd), 64'b01);
        chk("t1_tvalid", 64'(axi4s_out.tvalid), 1);
        chk("t1_beat0", axi4s_out.tdata, 64'h10);
        @(negedge clk);
        chk("t1_beat1", axi4s_out.tdata, 64'h11);
        chk("t1_rd1", 64'(src_rd), 64'b01);
        chk("t1_nodone", 64'(frm_done), 0);
        @(negedge clk);
        chk("t1_beat2", axi4s_out.tdata, 64'h12);
        chk("t1_done", 64'(frm_done), 1);
        chk("t1_beats", 64'(frm_beats), 3);
        chk("t1_fsrc", 64'(frm_src), 0);
        @(negedge clk);
        chk("t1_idle_after", 64'(grant_vld), 0);
        chk("t1_idle_tvalid", 64'(axi4s_out.tvalid), 0);
        chk("t1_rr_ptr", 64'(dut.rr_ptr_q), 1);

        // two 2-beat frames on each source, fresh pointer
        do_reset();
        clear_logs();
        push_frame(0, 2, 64'h20);
        push_frame(0, 2, 64'h22);
        push_frame(1, 2, 64'h30);
        push_frame(1, 2, 64'h32);
        wait_frames("t2_frames", 4, 60);
        exp_src = '{0, 1, 0, 1};
        exp_dat = '{64'h20, 64'h21, 64'h30, 64'h31,
                    64'h22, 64'h23, 64'h32, 64'h33};
        for (int j = 0; j < 4 && j < fsrc_log.size(); j++) begin
            chk($sformatf("t2_src%0d", j), 64'(fsrc_log[j]), 64'(exp_src[j]));
            chk($sformatf("t2_beats%0d", j), 64'(fbeats_log[j]), 2);
        end
        chk("t2_pops", 64'(pop_data.size()), 8);
        for (int j = 0; j < 8 && j < pop_data.size(); j++) begin
            chk($sformatf("t2_data%0d", j), pop_data[j], exp_dat[j]);
        end
        for (int j = 1; j < 8 && j < pop_cyc.size(); j++) begin
            chk($sformatf("t2_gap%0d", j), 64'(pop_cyc[j] - pop_cyc[j-1]),
                (j % 2 == 0) ? 64'd2 : 64'd1);
        end

        // backpressure mid-frame
        clear_logs();
        @(negedge clk);
        push_frame(0, 3, 64'h40);
        ob_rdy = 1'b1;
        @(negedge clk);
        chk("t3_rd_first", 64'(src_rd), 64'b01);
        @(negedge clk);
        ob_rdy = 1'b0;
        #1;
        chk("t3_stall_rd_a", 64'(src_rd), 0);
        chk("t3_stall_mstr", 64'(mstr_rd), 0);
        chk("t3_hold_beat_a", axi4s_out.tdata, 64'h41);
        chk("t3_gid_a", 64'(grant_id), 0);
        chk("t3_vld_a", 64'(grant_vld), 1);
        @(negedge clk);
        #1;
        chk("t3_stall_rd_b", 64'(src_rd), 0);
        chk("t3_hold_beat_b", axi4s_out.tdata, 64'h41);
        chk("t3_gid_b", 64'(grant_id), 0);
        ob_rdy = 1'b1;
        #1;
        chk("t3_resume_rd", 64'(src_rd), 64'b01);
        wait_frames("t3_frames", 1, 20);
        chk("t3_beats", 64'(fbeats_log.size() > 0 ? fbeats_log[0] : -1), 3);
        chk("t3_pops", 64'(pop_data.size()), 3);

        // SOT marker repeated on second beat
        clear_logs();
        push(0, 8'h01, 1'b0, 64'h50);
        push(0, 8'h01, 1'b0, 64'h51);
        push(0, 8'h00, 1'b1, 64'h52);
        wait_frames("t4_frames", 1, 20);
        chk("t4_err_cnt", 64'(err_cyc.size()), 1);
        a = (err_cyc.size() > 0) ? err_cyc[0] : -1;
        b = (pop_cyc.size() > 1) ? pop_cyc[1] : -2;
        chk("t4_err_pos", 64'(a), 64'(b));
        chk("t4_beats", 64'(fbeats_log.size() > 0 ? fbeats_log[0] : -1), 3);

        // 20-beat frame: full counter vs 4-bit saturating counter
        clear_logs();
        push_frame(0, 20, 64'h100);
        wait_frames("t5_frames", 1, 40);
        chk("t5_beats16", 64'(fbeats_log.size() > 0 ? fbeats_log[0] : -1), 20);
        chk("t5_beats4", 64'(sbeats_log.size() > 0 ? sbeats_log[0] : -1), 15);
        chk("t5_pops", 64'(pop_data.size()), 20);
        chk("t5_no_err", 64'(err_cyc.size()), 0);
        chk("t5_rr_ptr", 64'(dut.rr_ptr_q), 1);

        // reset during beat 2 of a src1 frame
        clear_logs();
        push_frame(1, 3, 64'h200);
        @(negedge clk);
        chk("t6_gid", 64'(grant_id), 1);
        @(negedge clk);
        chk("t6_beat2", axi4s_out.tdata, 64'h201);
        chk("t6_rd_pre", 64'(src_rd), 64'b10);
        rst_n = 1'b0;
        #1;
        chk("t6_rd", 64'(src_rd), 0);
        chk("t6_vld", 64'(grant_vld), 0);
        chk("t6_tvalid", 64'(axi4s_out.tvalid), 0);
        chk("t6_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("t6_rr_ptr", 64'(dut.rr_ptr_q), 0);
        flush();
        clear_logs();
        push_frame(1, 1, 64'h300);
        push_frame(0, 1, 64'h310);
        @(negedge clk);
        chk("t6_no_pop_rst", 64'(pop_data.size()), 0);
        rst_n = 1'b1;
        wait_frames("t6_frames", 2, 20);
        chk("t6_first_src", 64'(fsrc_log.size() > 0 ? fsrc_log[0] : -1), 0);
        chk("t6_second_src", 64'(fsrc_log.size() > 1 ? fsrc_log[1] : -1), 1);
        chk("t6_single_beats", 64'(fbeats_log.size() > 0 ? fbeats_log[0] : -1), 1);
        chk("t6_no_err", 64'(err_cyc.size()), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
